alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Initiator side of the 4-bit ALU interface (A, B, S in; Y[7:0] out).
- Accepts one operand pair over a valid/ready handshake.
- Drives the pair to the ALU with S stepping 0..N_OPS-1 on consecutive cycles and captures each Y into an internal result buffer.
- Then streams the results, tagged with their opcode, to a downstream consumer over a second valid/ready handshake.

Parameters:
- W_IN, 4, operand width (ALU A/B width)
- W_Y, 8, ALU result width
- N_OPS, 4, number of opcodes issued per operand pair; legal range 1..4

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept an operand pair
- in_a  input  W_IN  operand A
- in_b  input  W_IN  operand B
- alu_a  output  W_IN  registered operand A driven to ALU
- alu_b  output  W_IN  registered operand B driven to ALU
- alu_s  output  2  registered opcode driven to ALU
- alu_y  input  W_Y  ALU result; combinational from alu_a/alu_b/alu_s
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_s  output  2  opcode that produced out_y
- out_y  output  W_Y  result value
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - alu_a, alu_b, alu_s, out_s, out_y all 0.
  - out_valid=0, busy=0, done=0.
  - Result buffer and counters cleared.
  - Reset mid-ISSUE or mid-DRAIN abandons the operation; no partial results are emitted after reset deasserts.
- Handshake rules (both sides): a transfer occurs on a rising edge where valid and ready are both 1.
- in_ready is a state decode: 1 only in IDLE.
- out_valid is 1 only in DRAIN. While out_valid=1 and out_ready=0, out_s and out_y hold stable.
- FSM, three states:
  - IDLE: in_ready=1.
    - On an in_valid transfer: alu_a<=in_a, alu_b<=in_b, alu_s<=0, op_cnt<=0, next state ISSUE.
  - ISSUE: one cycle per opcode.
    - Each edge: buf[op_cnt]<=alu_y.
    - If op_cnt==N_OPS-1: rd_ptr<=0, next state DRAIN.
    - Otherwise: op_cnt<=op_cnt+1, alu_s<=op_cnt+1.
    - The ALU is sampled exactly once per opcode, in the cycle alu_s equals that opcode.
  - DRAIN: out_y=buf[rd_ptr], out_s=rd_ptr.
    - On an out_ready transfer with rd_ptr==N_OPS-1: next state IDLE, done pulses high for the following cycle (the first IDLE cycle).
    - Otherwise on a transfer: rd_ptr<=rd_ptr+1.
- Latency:
  - Input transfer at edge k.
  - ALU samples at edges k+1..k+N_OPS.
  - out_valid first high in the cycle after edge k+N_OPS.
  - With out_ready held high, the last result transfers at edge k+2·N_OPS; in_ready is high again after that edge.
- No overlap: a new operand pair is never accepted while results remain undelivered. in_valid is ignored outside IDLE.
- alu_a and alu_b hold their last operands after returning to IDLE; they change only on a new input transfer or reset.
- alu_y is treated as an unsigned W_Y-bit value and stored unmodified. No width conversion.
- Counters op_cnt and rd_ptr are 2 bits; no wrap beyond N_OPS-1 ever occurs.
- N_OPS=1: ISSUE lasts one cycle, DRAIN delivers one result with out_s=0.

Test Plan (bench ALU model: S0=A+B, S1=A−B mod 256, S2=A·B, S3={A,B}):
- Reset, then in_a=5, in_b=3, in_valid pulse, out_ready=1 → ALU sees S=0,1,2,3 on 4 consecutive cycles; outputs (s,y)=(0,8),(1,2),(2,15),(3,0x53); done pulses once; in_ready returns 1.
- in_a=3, in_b=5, out_ready toggling 0/1 every cycle → values (0,8),(1,0xFE),(2,15),(3,0x35); each held stable while out_ready=0; no duplicates or drops.
- Assert in_valid continuously with changing operands during ISSUE/DRAIN → only the pair present at the IDLE handshake is used; next pair is accepted only after done.
- Assert rst during ISSUE (after 2 ALU samples) → all outputs 0 immediately; after release, in_ready=1, out_valid=0, no stale results; a fresh pair 15,15 then yields (0,30),(1,0),(2,225),(3,0xFF).
- out_ready held 0 for 20 cycles in DRAIN → out_valid stays 1, out_s=0, out_y=first result constant, busy=1.
- N_OPS=1 build, in_a=9, in_b=9 → single result (0,18); ALU never sees S≠0; done one cycle after that transfer.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Initiator for a small combinational ALU: latches one operand pair, sweeps the opcodes,
// buffers each result, then streams (opcode, result) pairs to a downstream consumer.
module alu_op_sequencer #(
  parameter int unsigned W_IN  = 4,
  parameter int unsigned W_Y   = 8,
  parameter int unsigned N_OPS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_IN-1:0] in_a,
  input  logic [W_IN-1:0] in_b,
  output logic [W_IN-1:0] alu_a,
  output logic [W_IN-1:0] alu_b,
  output logic [1:0]      alu_s,
  input  logic [W_Y-1:0]  alu_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_s,
  output logic [W_Y-1:0]  out_y,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  localparam logic [1:0] LastOp = 2'(N_OPS - 1);

  state_e          state_q, state_d;
  logic [W_IN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]      alu_s_q, alu_s_d;
  logic [1:0]      op_cnt_q, op_cnt_d, rd_ptr_q, rd_ptr_d;
  logic [W_Y-1:0]  res_buf_q [4];
  logic            buf_we;
  logic            done_q, done_d;

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_s_d  = alu_s_q;
    op_cnt_d = op_cnt_q;
    rd_ptr_d = rd_ptr_q;
    buf_we   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          alu_a_d  = in_a;
          alu_b_d  = in_b;
          alu_s_d  = 2'd0;
          op_cnt_d = 2'd0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        // alu_y reflects alu_s == op_cnt during this cycle
        buf_we = 1'b1;
        if (op_cnt_q == LastOp) begin
          rd_ptr_d = 2'd0;
          state_d  = StDrain;
        end else begin
          op_cnt_d = op_cnt_q + 2'd1;
          alu_s_d  = op_cnt_q + 2'd1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (rd_ptr_q == LastOp) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_s_q  <= '0;
      op_cnt_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 4; i++) res_buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_s_q  <= alu_s_d;
      op_cnt_q <= op_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
      if (buf_we) res_buf_q[op_cnt_q] <= alu_y;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDrain);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign out_s     = out_valid ? rd_ptr_q : 2'd0;
  assign out_y     = out_valid ? res_buf_q[rd_ptr_q] : '0;

endmodule
